// File: rtl/iob_pkg.sv
// Shared IOb bus definitions: bus widths and the responder FSM state encoding.
package iob_pkg;

  localparam int IOB_ADDR_W = 32;
  localparam int IOB_DATA_W = 32;
  localparam int IOB_STRB_W = IOB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } iob_state_e;

endpackage

// File: rtl/iob_mem_responder_if.sv
// IOb request/response bundle; signal names follow the subordinate's point of view.
interface iob_mem_responder_if
  import iob_pkg::*;
#(
  parameter int ADDR_W = IOB_ADDR_W,
  parameter int DATA_W = IOB_DATA_W
) ();

  localparam int STRB_W = DATA_W / 8;

  logic              iob_valid_i;
  logic [ADDR_W-1:0] iob_addr_i;
  logic [DATA_W-1:0] iob_wdata_i;
  logic [STRB_W-1:0] iob_wstrb_i;
  logic              iob_ready_o;
  logic [DATA_W-1:0] iob_rdata_o;

  modport master (
    output iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    input  iob_ready_o, iob_rdata_o
  );

  modport slave (
    input  iob_valid_i, iob_addr_i, iob_wdata_i, iob_wstrb_i,
    output iob_ready_o, iob_rdata_o
  );

endinterface

// File: rtl/iob_sp_ram.sv
// Single-port RAM with per-byte write enables and a registered read port.
module iob_sp_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [STRB_W-1:0] we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [0:(1 << ADDR_W) - 1];

  // Read when no lane is enabled, otherwise commit the enabled byte lanes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we == '0) begin
        dout <= mem_q[addr];
      end
      for (int i = 0; i < STRB_W; i++) begin
        if (we[i]) begin
          mem_q[addr][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/iob_mem_responder.sv
// IOb subordinate backed by a byte-enabled RAM, answering each request with a
// single ready pulse after a fixed number of wait states.
module iob_mem_responder
  import iob_pkg::*;
#(
  parameter int                ADDR_W         = IOB_ADDR_W,
  parameter int                DATA_W         = IOB_DATA_W,
  parameter int                MEM_DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter int                WAIT_CYCLES    = 2
) (
  input  logic               clk,
  input  logic               reset,
  iob_mem_responder_if.slave iob,
  output logic               busy_o,
  output logic               err_o
);

  localparam int         STRB_W    = DATA_W / 8;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  iob_state_e                state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic                      ready_q, ready_d;
  logic                      busy_q, busy_d;
  logic                      err_q, err_d;
  logic                      rd_ok_q, rd_ok_d;

  logic [ADDR_W-1:0]         req_addr_s;
  logic [ADDR_W-1:0]         offset_s;
  logic [STRB_W-1:0]         req_wstrb_s;
  logic                      oor_s;
  logic                      enter_resp_s;
  logic                      wr_commit_s;
  logic                      ram_en_s;
  logic [STRB_W-1:0]         ram_we_s;
  logic [MEM_DEPTH_LOG2-1:0] ram_idx_s;
  logic [DATA_W-1:0]         ram_dout_s;

  // In IDLE the live bus request is decoded so a zero-wait access can read on accept.
  assign req_addr_s  = (state_q == IDLE) ? iob.iob_addr_i  : addr_q;
  assign req_wstrb_s = (state_q == IDLE) ? iob.iob_wstrb_i : wstrb_q;
  assign offset_s    = req_addr_s - BASE_ADDR;
  assign oor_s       = (req_addr_s < BASE_ADDR) || ((offset_s >> (MEM_DEPTH_LOG2 + 2)) != '0);
  assign ram_idx_s   = offset_s[MEM_DEPTH_LOG2+1:2];

  // Next-state, request latches and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    case (state_q)
      IDLE: begin
        if (iob.iob_valid_i) begin
          addr_d  = iob.iob_addr_i;
          wdata_d = iob.iob_wdata_i;
          wstrb_d = iob.iob_wstrb_i;
          cnt_d   = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (!iob.iob_valid_i) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    enter_resp_s = (state_d == RESP) && (state_q != RESP);
    ready_d      = (state_d == RESP);
    busy_d       = (state_d != IDLE);
    err_d        = err_q | (enter_resp_s & oor_s);
    rd_ok_d      = enter_resp_s & ~oor_s & (req_wstrb_s == '0);
    wr_commit_s  = (state_q == RESP) && (wstrb_q != '0) && !oor_s && reset;
    ram_en_s     = rd_ok_d | wr_commit_s;
    ram_we_s     = wr_commit_s ? wstrb_q : '0;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  iob_sp_ram #(
    .ADDR_W (MEM_DEPTH_LOG2),
    .DATA_W (DATA_W),
    .STRB_W (STRB_W)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en_s),
    .we   (ram_we_s),
    .addr (ram_idx_s),
    .din  (wdata_q),
    .dout (ram_dout_s)
  );

  assign iob.iob_ready_o = ready_q;
  assign iob.iob_rdata_o = rd_ok_q ? ram_dout_s : '0;
  assign busy_o          = busy_q;
  assign err_o           = err_q;

endmodule
